cpu_eu_param: RTL

CPU_EU_PARAM -- requirements
Module: cpu_eu_param

---
 rtl/cpu_eu_param.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cpu_eu_param.sv
// Parameterised CPU execution unit: register file, ALU, flags, PC and IR.
// All state is synchronous to clock with an active-low synchronous reset.
module cpu_eu_param #(
  parameter int              DW       = 16,
  parameter int              NREG     = 8,
  parameter int              OFS_W    = 9,
  parameter logic [DW-1:0]   RESET_PC = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     w_en,
  input  logic                     s_sel,
  input  logic                     flag_ld,
  input  logic                     pc_ld,
  input  logic                     pc_inc,
  input  logic                     pc_sel,
  input  logic                     adr_sel,
  input  logic                     ir_ld,
  input  logic [$clog2(NREG)-1:0]  w_adr,
  input  logic [$clog2(NREG)-1:0]  r_adr,
  input  logic [$clog2(NREG)-1:0]  s_adr,
  input  logic [3:0]               alu_op,
  input  logic [DW-1:0]            d_in,
  output logic [DW-1:0]            alu_out,
  output logic [DW-1:0]            reg_out,
  output logic [DW-1:0]            address,
  output logic [DW-1:0]            ir_out,
  output logic                     carry,
  output logic                     n,
  output logic                     z,
  output logic                     v
);

  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          c_q, c_d;
  logic          n_q, n_d;
  logic          z_q, z_d;
  logic          v_q, v_d;

  logic [DW-1:0] r_val, s_val;
  logic [DW-1:0] add_x, add_y;
  logic          add_ci;
  logic          is_arith;
  logic [DW:0]   sum;
  logic [DW-1:0] alu_res;
  logic          c_nxt, v_nxt;
  logic [DW-1:0] ofs;

  always_comb begin
    r_val = rf_q[r_adr];
    s_val = s_sel ? d_in : rf_q[s_adr];
  end

  // One shared adder; subtraction is X + ~Y + 1
  always_comb begin
    add_x    = r_val;
    add_y    = s_val;
    add_ci   = 1'b0;
    is_arith = 1'b0;
    case (alu_op)
      4'h2: is_arith = 1'b1;
      4'h3: begin
        add_y    = ~s_val;
        add_ci   = 1'b1;
        is_arith = 1'b1;
      end
      4'h4: begin
        add_x    = s_val;
        add_y    = ~r_val;
        add_ci   = 1'b1;
        is_arith = 1'b1;
      end
      4'h9: begin
        add_y    = '0;
        add_ci   = 1'b1;
        is_arith = 1'b1;
      end
      4'hA: begin
        add_y    = '1;
        is_arith = 1'b1;
      end
      default: ;
    endcase
    sum = {1'b0, add_x} + {1'b0, add_y}
        + {{DW{1'b0}}, add_ci};
  end

  always_comb begin
    alu_res = '0;
    c_nxt   = 1'b0;
    case (alu_op)
      4'h0: alu_res = r_val;
      4'h1: alu_res = s_val;
      4'h5: alu_res = r_val & s_val;
      4'h6: alu_res = r_val | s_val;
      4'h7: alu_res = r_val ^ s_val;
      4'h8: alu_res = ~r_val;
      4'hB: begin
        alu_res = {r_val[DW-2:0], 1'b0};
        c_nxt   = r_val[DW-1];
      end
      4'hC: begin
        alu_res = {1'b0, r_val[DW-1:1]};
        c_nxt   = r_val[0];
      end
      4'hD: begin
        alu_res = {r_val[DW-1], r_val[DW-1:1]};
        c_nxt   = r_val[0];
      end
      4'hE: begin
        alu_res = {r_val[DW-2:0], r_val[DW-1]};
        c_nxt   = r_val[DW-1];
      end
      4'hF: alu_res = '0;
      default: begin
        alu_res = sum[DW-1:0];
        c_nxt   = sum[DW];
      end
    endcase
    v_nxt = is_arith
          & (add_x[DW-1] == add_y[DW-1])
          & (sum[DW-1] != add_x[DW-1]);
  end

  assign ofs = {{(DW-OFS_W){ir_q[OFS_W-1]}},
                ir_q[OFS_W-1:0]};

  always_comb begin
    rf_d = rf_q;
    if (w_en) rf_d[w_adr] = alu_res;
    ir_d = ir_ld ? d_in : ir_q;
    pc_d = pc_q;
    if (pc_ld)       pc_d = pc_sel ? alu_res : pc_q + ofs;
    else if (pc_inc) pc_d = pc_q + 1'b1;
    c_d = flag_ld ? c_nxt : c_q;
    n_d = flag_ld ? alu_res[DW-1] : n_q;
    z_d = flag_ld ? (alu_res == '0) : z_q;
    v_d = flag_ld ? v_nxt : v_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      pc_q <= RESET_PC;
      ir_q <= '0;
      c_q  <= 1'b0;
      n_q  <= 1'b0;
      z_q  <= 1'b0;
      v_q  <= 1'b0;
    end else begin
      rf_q <= rf_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      c_q  <= c_d;
      n_q  <= n_d;
      z_q  <= z_d;
      v_q  <= v_d;
    end
  end

  assign alu_out = alu_res;
  assign reg_out = r_val;
  assign address = adr_sel ? r_val : pc_q;
  assign ir_out  = ir_q;
  assign carry   = c_q;
  assign n       = n_q;
  assign z       = z_q;
  assign v       = v_q;

endmodule
